// File: rtl/pts_pkg.sv
// Shared types and constants for the packed table streamer.
package pts_pkg;

  localparam int unsigned PTS_DEPTH = 4;
  localparam int unsigned PTS_DW    = 8;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
  } nib_pair_t;

  typedef nib_pair_t table_t [PTS_DEPTH-1:0];

  // Entry 0 sits in the least significant byte.
  localparam logic [PTS_DEPTH*PTS_DW-1:0] TABLE_INIT = {8'h11, 8'h22, 8'h33, 8'h44};

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FINISH
  } pts_state_e;

endpackage

// File: rtl/pts_table_regs.sv
// Register array with asynchronous reset-to-image, one write port and one
// combinational read port.
module pts_table_regs #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 8,
  parameter int unsigned IW    = $clog2(DEPTH),
  parameter logic [DEPTH*DW-1:0] INIT = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_wr_en,
  input  logic [IW-1:0] i_wr_idx,
  input  logic [DW-1:0] i_wr_data,
  input  logic [IW-1:0] i_rd_idx,
  output logic [DW-1:0] o_rd_data
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= INIT[i*DW +: DW];
      end
    end else if (i_wr_en) begin
      r_mem[i_wr_idx] <= i_wr_data;
    end
  end

  // Read sees the pre-edge contents, so a same-edge write never reaches the loaded beat.
  assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/packed_table_streamer.sv
// Streams a run of table entries in index order over a valid/ready byte
// interface, with each beat also split into its high and low nibbles.
module packed_table_streamer
  import pts_pkg::*;
#(
  parameter int unsigned DEPTH = PTS_DEPTH,
  parameter int unsigned DW    = PTS_DW,
  parameter logic [DEPTH*DW-1:0] INIT = TABLE_INIT,
  localparam int unsigned IW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [IW-1:0]   wr_idx,
  input  logic [DW-1:0]   wr_data,
  input  logic            start,
  input  logic [IW-1:0]   start_idx,
  input  logic [IW:0]     count,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_byte,
  output logic [DW/2-1:0] out_hi,
  output logic [DW/2-1:0] out_lo,
  output logic            out_bit0,
  output logic            busy,
  output logic            done
);

  pts_state_e    r_state, w_state_nxt;
  logic [IW-1:0] r_ptr, w_rd_idx;
  logic [IW:0]   r_rem, w_clamp;
  logic [DW-1:0] r_byte, w_rd_data;
  logic          r_valid;
  logic          w_hs, w_first, w_advance, w_last;

  pts_table_regs #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .IW    (IW),
    .INIT  (INIT)
  ) u_table (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (wr_en),
    .i_wr_idx  (wr_idx),
    .i_wr_data (wr_data),
    .i_rd_idx  (w_rd_idx),
    .o_rd_data (w_rd_data)
  );

  assign w_hs    = r_valid && out_ready;
  assign w_clamp = (count > (IW+1)'(DEPTH)) ? (IW+1)'(DEPTH) : count;

  always_comb begin
    w_state_nxt = r_state;
    w_first     = 1'b0;
    w_advance   = 1'b0;
    w_last      = 1'b0;
    w_rd_idx    = r_ptr + 1'b1;
    case (r_state)
      IDLE: begin
        w_rd_idx = start_idx;
        if (start) begin
          if (count != '0) begin
            w_first     = 1'b1;
            w_state_nxt = STREAM;
          end else begin
            w_state_nxt = FINISH;
          end
        end
      end
      STREAM: begin
        if (w_hs) begin
          if (r_rem > (IW+1)'(1)) begin
            w_advance = 1'b1;
          end else begin
            w_last      = 1'b1;
            w_state_nxt = FINISH;
          end
        end
      end
      FINISH:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_rem   <= '0;
      r_byte  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_first) begin
        r_ptr   <= start_idx;
        r_rem   <= w_clamp;
        r_byte  <= w_rd_data;
        r_valid <= 1'b1;
      end else if (w_advance) begin
        r_ptr   <= w_rd_idx;
        r_rem   <= r_rem - 1'b1;
        r_byte  <= w_rd_data;
      end else if (w_last) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_byte  = r_byte;
  assign out_hi    = r_byte[DW-1:DW/2];
  assign out_lo    = r_byte[DW/2-1:0];
  assign out_bit0  = r_byte[0];
  assign busy      = (r_state == STREAM);
  assign done      = (r_state == FINISH);

endmodule

// File: tb/tb_packed_table_streamer.sv
// Scoreboard bench: stimulus queues expected beats, a negedge monitor pops
// and compares each accepted beat.
module tb_packed_table_streamer;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [1:0] wr_idx;
  logic [7:0] wr_data;
  logic       start;
  logic [1:0] start_idx;
  logic [2:0] count;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_byte;
  logic [3:0] out_hi;
  logic [3:0] out_lo;
  logic       out_bit0;
  logic       busy;
  logic       done;

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;
  logic [7:0]  exp_q [$];

  always #5 clk = ~clk;

  packed_table_streamer dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_data   (wr_data),
    .start     (start),
    .start_idx (start_idx),
    .count     (count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_byte  (out_byte),
    .out_hi    (out_hi),
    .out_lo    (out_lo),
    .out_bit0  (out_bit0),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {24'h0, out_byte}, 32'hFFFF_FFFF);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("beat_byte", {24'h0, out_byte}, {24'h0, e});
        check("beat_hi",   {28'h0, out_hi},   {28'h0, e[7:4]});
        check("beat_lo",   {28'h0, out_lo},   {28'h0, e[3:0]});
        check("beat_bit0", {31'h0, out_bit0}, {31'h0, e[0]});
      end
    end
  end

  task automatic start_run(input logic [1:0] idx, input logic [2:0] cnt);
    @(posedge clk); #1;
    start     = 1'b1;
    start_idx = idx;
    count     = cnt;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  // Counts negedges until done; expected cycle is beats+1 after the start edge.
  task automatic wait_done(input string name, input int exp_cyc);
    int c;
    c = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done) begin
        c = i;
        break;
      end
    end
    if (c == 0) begin
      check({name, "_done_timeout"}, 32'd0, 32'd1);
    end else begin
      check({name, "_done_cycle"}, c, exp_cyc);
      @(negedge clk);
      check({name, "_done_pulse_width"}, {31'h0, done}, 32'd0);
      check({name, "_busy_after"}, {31'h0, busy}, 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_data = '0;
    start = 1'b0; start_idx = '0; count = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", {31'h0, out_valid}, 32'd0);
    check("rst_byte",  {24'h0, out_byte},  32'd0);
    check("rst_busy",  {31'h0, busy},      32'd0);
    check("rst_done",  {31'h0, done},      32'd0);
    @(posedge clk); #1; rst = 1'b0;

    // Single beat from entry 1.
    exp_q.push_back(8'h33);
    start_run(2'd1, 3'd1);
    check("t1_busy", {31'h0, busy}, 32'd1);
    wait_done("t1", 2);

    // Wrap 3 -> 0 -> 1.
    exp_q.push_back(8'h11); exp_q.push_back(8'h44); exp_q.push_back(8'h33);
    start_run(2'd3, 3'd3);
    wait_done("t2", 4);

    // Write then read back entry 2.
    @(posedge clk); #1; wr_en = 1'b1; wr_idx = 2'd2; wr_data = 8'hAB;
    @(posedge clk); #1; wr_en = 1'b0;
    exp_q.push_back(8'hAB);
    start_run(2'd2, 3'd1);
    wait_done("t3", 2);

    // Stall with ready low; write to held entry must not disturb the beat.
    out_ready = 1'b0;
    exp_q.push_back(8'h44); exp_q.push_back(8'h33);
    start_run(2'd0, 3'd2);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin wr_en = 1'b1; wr_idx = 2'd0; wr_data = 8'h00; end
      @(negedge clk);
      check("t4_stall_valid", {31'h0, out_valid}, 32'd1);
      check("t4_stall_byte",  {24'h0, out_byte},  32'h44);
      @(posedge clk); #1; wr_en = 1'b0;
    end
    out_ready = 1'b1;
    wait_done("t4", 3);

    // Zero-length run.
    start_run(2'd0, 3'd0);
    wait_done("t5", 1);

    // Count clamp: 7 -> 4 beats starting at entry 1.
    exp_q.push_back(8'h33); exp_q.push_back(8'hAB);
    exp_q.push_back(8'h11); exp_q.push_back(8'h00);
    start_run(2'd1, 3'd7);
    wait_done("t6", 5);

    // Same-edge write to the loaded entry yields the old value; a start while
    // streaming is ignored.
    exp_q.push_back(8'h33); exp_q.push_back(8'hAB);
    @(posedge clk); #1;
    start = 1'b1; start_idx = 2'd1; count = 3'd2;
    wr_en = 1'b1; wr_idx = 2'd1; wr_data = 8'h5A;
    @(posedge clk); #1;
    wr_en = 1'b0; start_idx = 2'd3; count = 3'd4;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("t7", 2);

    // Reset after two of four beats.
    exp_q.push_back(8'h00); exp_q.push_back(8'h5A);
    start_run(2'd0, 3'd4);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("t8_rst_valid", {31'h0, out_valid}, 32'd0);
    check("t8_rst_byte",  {24'h0, out_byte},  32'd0);
    check("t8_rst_hi",    {28'h0, out_hi},    32'd0);
    check("t8_rst_lo",    {28'h0, out_lo},    32'd0);
    check("t8_rst_bit0",  {31'h0, out_bit0},  32'd0);
    check("t8_rst_busy",  {31'h0, busy},      32'd0);
    @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t8_no_done", {31'h0, done}, 32'd0);
    end

    // Table restored to its init image.
    exp_q.push_back(8'h44); exp_q.push_back(8'h33);
    exp_q.push_back(8'h22); exp_q.push_back(8'h11);
    start_run(2'd0, 3'd4);
    wait_done("t9", 5);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
